// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared opcodes, ALUOp encodings, FSM states and control bundle
//             for the multi-cycle RISC-V control unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] OP_R          = 7'b0110011;
    localparam logic [6:0] OP_IMM        = 7'b0010011;
    localparam logic [6:0] OP_LOAD       = 7'b0000011;
    localparam logic [6:0] OP_STORE      = 7'b0100011;
    localparam logic [6:0] OP_BRANCH     = 7'b1100011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_I  = 2'b00;
    localparam logic [1:0] ALUOP_S  = 2'b01;
    localparam logic [1:0] ALUOP_R  = 2'b10;
    localparam logic [1:0] ALUOP_SB = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       branch;
        logic [1:0] aluop;
        logic       valid;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // Writeback bundle shared by plain R-type ops and completed M ops.
    function automatic ctrl_bundle_t r_type_bundle();
        ctrl_bundle_t b;
        b          = BUBBLE;
        b.regwrite = 1'b1;
        b.aluop    = ALUOP_R;
        b.valid    = 1'b1;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
//  Module   : ctrl_decode
//  Purpose  : Combinational opcode/funct7 decode into a control bundle plus
//             M-extension and illegal-opcode flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [6:0]   funct7,
    output ctrl_bundle_t bundle,
    output logic         is_mdu,
    output logic         illegal
);

    always_comb begin
        bundle  = BUBBLE;
        is_mdu  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                // M ops leave the bundle empty; the sequencer issues it later.
                if (funct7 == FUNCT7_MULDIV) begin
                    is_mdu = 1'b1;
                end else begin
                    bundle = r_type_bundle();
                end
            end
            OP_IMM: begin
                bundle.regwrite = 1'b1;
                bundle.alusrc   = 1'b1;
                bundle.aluop    = ALUOP_I;
                bundle.valid    = 1'b1;
            end
            OP_LOAD: begin
                bundle.regwrite = 1'b1;
                bundle.memtoreg = 1'b1;
                bundle.memread  = 1'b1;
                bundle.alusrc   = 1'b1;
                bundle.aluop    = ALUOP_I;
                bundle.valid    = 1'b1;
            end
            OP_STORE: begin
                bundle.memwrite = 1'b1;
                bundle.alusrc   = 1'b1;
                bundle.aluop    = ALUOP_S;
                bundle.valid    = 1'b1;
            end
            OP_BRANCH: begin
                bundle.branch = 1'b1;
                bundle.aluop  = ALUOP_SB;
                bundle.valid  = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_unit_mc.sv
// ============================================================================
//  Module   : ctrl_unit_mc
//  Purpose  : Registered ID/EX control bundle with stall/flush/NoOp handling
//             and an RV32M MUL/DIV sequencer. Define CTRL_PERF_EN to add the
//             bubble and MDU-busy performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_unit_mc
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W    = 2,
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        inst_i,
    input  logic               valid_i,
    input  logic               noop_i,
    input  logic               flush_i,
    input  logic               stall_i,
    output logic               regwrite_o,
    output logic               memtoreg_o,
    output logic               memread_o,
    output logic               memwrite_o,
    output logic               alusrc_o,
    output logic               branch_o,
    output logic [ALUOP_W-1:0] aluop_o,
    output logic               valid_o,
    output logic               mdu_start_o,
    output logic [2:0]         mdu_op_o,
    output logic               mdu_kill_o,
    output logic               busy_o,
    output logic               illegal_o
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]        perf_bubble_o,
    output logic [31:0]        perf_mdu_o
`endif
);

    localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

    state_t       state, state_next;
    logic [7:0]   cnt, cnt_next;
    ctrl_bundle_t ctrl, ctrl_next;
    logic [2:0]   mdu_op, mdu_op_next;
    logic         busy, busy_next;
    logic         start, start_next;
    logic         kill, kill_next;
    logic         illegal, illegal_next;
    logic         advance;

    ctrl_bundle_t dec_bundle;
    logic         dec_is_mdu;
    logic         dec_illegal;
    logic         unused_inst_bits;

    assign unused_inst_bits = ^{inst_i[24:15], inst_i[11:7]};

    ctrl_decode u_decode (
        .opcode  (inst_i[6:0]),
        .funct7  (inst_i[31:25]),
        .bundle  (dec_bundle),
        .is_mdu  (dec_is_mdu),
        .illegal (dec_illegal)
    );

    // Flush overrides stall; a plain stall freezes everything.
    assign advance = flush_i || !stall_i;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        mdu_op_next  = mdu_op;
        busy_next    = busy;
        ctrl_next    = BUBBLE;
        start_next   = 1'b0;
        kill_next    = 1'b0;
        illegal_next = 1'b0;
        if (flush_i) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            kill_next  = (state == BUSY);
        end else if (state == BUSY) begin
            if (cnt != 8'd0) begin
                cnt_next = cnt - 8'd1;
            end else begin
                state_next = ISSUE;
                busy_next  = 1'b0;
                ctrl_next  = r_type_bundle();
            end
        end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
            if (valid_i && !noop_i) begin
                if (dec_is_mdu) begin
                    state_next  = BUSY;
                    busy_next   = 1'b1;
                    start_next  = 1'b1;
                    mdu_op_next = inst_i[14:12];
                    cnt_next    = inst_i[14] ? DIV_LOAD : MUL_LOAD;
                end else begin
                    ctrl_next    = dec_bundle;
                    illegal_next = dec_illegal;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            ctrl    <= BUBBLE;
            mdu_op  <= 3'd0;
            busy    <= 1'b0;
            start   <= 1'b0;
            kill    <= 1'b0;
            illegal <= 1'b0;
        end else if (advance) begin
            state   <= state_next;
            cnt     <= cnt_next;
            ctrl    <= ctrl_next;
            mdu_op  <= mdu_op_next;
            busy    <= busy_next;
            start   <= start_next;
            kill    <= kill_next;
            illegal <= illegal_next;
        end else begin
            // Pulses must not repeat while the pipeline is frozen.
            start   <= 1'b0;
            kill    <= 1'b0;
            illegal <= 1'b0;
        end
    end

    assign regwrite_o  = ctrl.regwrite;
    assign memtoreg_o  = ctrl.memtoreg;
    assign memread_o   = ctrl.memread;
    assign memwrite_o  = ctrl.memwrite;
    assign alusrc_o    = ctrl.alusrc;
    assign branch_o    = ctrl.branch;
    assign aluop_o     = ALUOP_W'(ctrl.aluop);
    assign valid_o     = ctrl.valid;
    assign mdu_start_o = start;
    assign mdu_op_o    = mdu_op;
    assign mdu_kill_o  = kill;
    assign busy_o      = busy;
    assign illegal_o   = illegal;

`ifdef CTRL_PERF_EN
    logic [31:0] bubble_cnt;
    logic [31:0] mdu_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bubble_cnt <= 32'd0;
            mdu_cnt    <= 32'd0;
        end else if (advance) begin
            if ((state != BUSY) && !ctrl_next.valid) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (busy) begin
                mdu_cnt <= mdu_cnt + 32'd1;
            end
        end
    end

    assign perf_bubble_o = bubble_cnt;
    assign perf_mdu_o    = mdu_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_unit_mc.sv
// ============================================================================
//  Module   : tb_ctrl_unit_mc
//  Purpose  : Directed table-driven and sequence checks for ctrl_unit_mc.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_unit_mc;

    logic        clk;
    logic        rst_i;
    logic [31:0] inst_i;
    logic        valid_i, noop_i, flush_i, stall_i;
    logic        regwrite_o, memtoreg_o, memread_o, memwrite_o, alusrc_o, branch_o;
    logic [1:0]  aluop_o;
    logic        valid_o, mdu_start_o, mdu_kill_o, busy_o, illegal_o;
    logic [2:0]  mdu_op_o;
`ifdef CTRL_PERF_EN
    logic [31:0] perf_bubble_o, perf_mdu_o;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    // {regwrite, memtoreg, memread, memwrite, alusrc, branch, aluop, valid}
    localparam logic [8:0] B_NONE = 9'b0_0_0_0_0_0_00_0;
    localparam logic [8:0] B_I    = 9'b1_0_0_0_1_0_00_1;
    localparam logic [8:0] B_LD   = 9'b1_1_1_0_1_0_00_1;
    localparam logic [8:0] B_ST   = 9'b0_0_0_1_1_0_01_1;
    localparam logic [8:0] B_BR   = 9'b0_0_0_0_0_1_11_1;
    localparam logic [8:0] B_R    = 9'b1_0_0_0_0_0_10_1;

    ctrl_unit_mc #(
        .ALUOP_W    (2),
        .MUL_CYCLES (3),
        .DIV_CYCLES (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .inst_i      (inst_i),
        .valid_i     (valid_i),
        .noop_i      (noop_i),
        .flush_i     (flush_i),
        .stall_i     (stall_i),
        .regwrite_o  (regwrite_o),
        .memtoreg_o  (memtoreg_o),
        .memread_o   (memread_o),
        .memwrite_o  (memwrite_o),
        .alusrc_o    (alusrc_o),
        .branch_o    (branch_o),
        .aluop_o     (aluop_o),
        .valid_o     (valid_o),
        .mdu_start_o (mdu_start_o),
        .mdu_op_o    (mdu_op_o),
        .mdu_kill_o  (mdu_kill_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o)
`ifdef CTRL_PERF_EN
        ,
        .perf_bubble_o (perf_bubble_o),
        .perf_mdu_o    (perf_mdu_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        noop;
        logic        flush;
        logic        stall;
        logic [8:0]  exp_ctrl;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [8:0] bundle_now();
        return {regwrite_o, memtoreg_o, memread_o, memwrite_o, alusrc_o, branch_o,
                aluop_o, valid_o};
    endfunction

    // {bundle, illegal, start, kill, busy}
    function automatic logic [12:0] snap();
        return {bundle_now(), illegal_o, mdu_start_o, mdu_kill_o, busy_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic v, input logic n,
                         input logic f, input logic s);
        inst_i  = inst;
        valid_i = v;
        noop_i  = n;
        flush_i = f;
        stall_i = s;
    endtask

    // Accepts an M op and follows it to the writeback bundle, with the first
    // nstall sequencer edges stalled.
    task automatic mdu_run(input string name, input logic [31:0] inst, input int lat,
                           input int nstall);
        int  busy_cycles;
        int  starts;
        bool_done: begin end
        drive(inst, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check({name, " accept"}, {19'd0, mdu_start_o, busy_o, mdu_op_o, bundle_now()},
              {19'd0, 1'b1, 1'b1, inst[14:12], B_NONE});
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        busy_cycles = 1;
        starts      = 1;
        for (int i = 0; i < lat + nstall + 4; i++) begin
            stall_i = (i < nstall);
            step();
            if (mdu_start_o) starts++;
            if (!busy_o) break;
            busy_cycles++;
            if (bundle_now() != B_NONE) begin
                check({name, " busy bubble"}, {23'd0, bundle_now()}, {23'd0, B_NONE});
            end
        end
        stall_i = 1'b0;
        check({name, " issue bundle"}, {22'd0, busy_o, bundle_now()}, {22'd0, 1'b0, B_R});
        check({name, " busy cycles"}, busy_cycles, lat + nstall);
        check({name, " start pulses"}, starts, 1);
    endtask

    initial begin
        vecs[0]  = '{I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, B_I,    1'b0};
        vecs[1]  = '{I_LW,   1'b1, 1'b0, 1'b0, 1'b0, B_LD,   1'b0};
        vecs[2]  = '{I_SW,   1'b1, 1'b0, 1'b0, 1'b0, B_ST,   1'b0};
        vecs[3]  = '{I_BEQ,  1'b1, 1'b0, 1'b0, 1'b0, B_BR,   1'b0};
        vecs[4]  = '{I_ADD,  1'b1, 1'b0, 1'b0, 1'b0, B_R,    1'b0};
        vecs[5]  = '{I_ADD,  1'b0, 1'b0, 1'b0, 1'b0, B_NONE, 1'b0};
        vecs[6]  = '{I_BAD,  1'b1, 1'b0, 1'b0, 1'b0, B_NONE, 1'b1};
        vecs[7]  = '{I_ADD,  1'b1, 1'b1, 1'b0, 1'b0, B_NONE, 1'b0};
        vecs[8]  = '{I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0, B_I,    1'b0};
        vecs[9]  = '{I_ADD,  1'b1, 1'b0, 1'b1, 1'b0, B_NONE, 1'b0};
        vecs[10] = '{I_ADD,  1'b1, 1'b0, 1'b0, 1'b0, B_R,    1'b0};
        vecs[11] = '{I_SW,   1'b1, 1'b0, 1'b0, 1'b1, B_R,    1'b0};
        vecs[12] = '{I_ADD,  1'b1, 1'b0, 1'b1, 1'b1, B_NONE, 1'b0};
        vecs[13] = '{I_SUB,  1'b1, 1'b0, 1'b0, 1'b0, B_R,    1'b0};
        vecs[14] = '{I_BAD,  1'b1, 1'b0, 1'b0, 1'b0, B_NONE, 1'b1};
        vecs[15] = '{I_BAD,  1'b1, 1'b0, 1'b0, 1'b1, B_NONE, 1'b0};

        // Reset wins even with a valid instruction presented.
        rst_i = 1'b0;
        drive(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset outputs", {16'd0, mdu_op_o, snap()}, 32'd0);
        end
        rst_i = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].inst, vecs[i].valid, vecs[i].noop, vecs[i].flush, vecs[i].stall);
            step();
            check($sformatf("vec%0d", i), {19'd0, snap()},
                  {19'd0, vecs[i].exp_ctrl, vecs[i].exp_illegal, 3'b000});
        end

        // MUL followed by an addi decoded in the ISSUE cycle.
        mdu_run("mul", I_MUL, 3, 0);
        drive(I_ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("back-to-back addi", {19'd0, snap()}, {19'd0, B_I, 4'b0000});
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        mdu_run("div", I_DIV, 32, 0);
        step();
        mdu_run("mul stall", I_MUL, 3, 4);
        step();

        // DIV flushed in its 5th busy cycle.
        drive(I_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("div still busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        step();
        check("div flush", {19'd0, snap()}, {19'd0, B_NONE, 4'b0010});
        drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("add after flush", {19'd0, snap()}, {19'd0, B_R, 4'b0000});

        // Stall and flush together inside a MUL.
        drive(I_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check("stall+flush", {19'd0, snap()}, {19'd0, B_NONE, 4'b0010});
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("kill single pulse", {19'd0, snap()}, 32'd0);

        // Reset mid-MDU aborts without a kill pulse.
        drive(I_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        step();
        check("reset mid-mdu", {16'd0, mdu_op_o, snap()}, 32'd0);
        rst_i = 1'b1;
        step();
        check("idle after reset", {19'd0, snap()}, 32'd0);

`ifdef CTRL_PERF_EN
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step();
        drive(I_BAD, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive(I_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("perf bubbles", perf_bubble_o, 32'd10);
        check("perf mdu idle", perf_mdu_o, 32'd0);
        stall_i = 1'b0;
        mdu_run("perf mul", I_MUL, 3, 0);
        check("perf mdu cycles", perf_mdu_o, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ctrl_unit_mc.md
Name: ctrl_unit_mc

Overview:
- Next-generation control unit for the pipelined RISC-V core; sits in ID and drives the ID/EX control fields.
- Decodes opcode/funct3/funct7 of the full instruction and registers the control bundle, acting as the control half of the ID/EX register.
- Adds stall, flush and NoOp handling.
- Adds a multi-cycle sequencer for RV32M MUL/DIV: it starts the MDU, holds the front end via busy_o, then issues the writeback bundle.

Parameters:
- ALUOP_W, 2, width of aluop_o. Encodings: I=00, S=01, R=10, SB=11; upper bits zero if wider.
- MUL_CYCLES, 3, busy cycles for funct3[2]=0 (MUL*). Legal range 1..255.
- DIV_CYCLES, 32, busy cycles for funct3[2]=1 (DIV/REM). Legal range 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-low.
- inst_i  in  32  instruction in ID. Held stable by upstream while busy_o=1.
- valid_i  in  1  inst_i is valid.
- noop_i  in  1  hazard bubble request from the hazard detection unit.
- flush_i  in  1  branch flush; kills the ID instruction and any MDU op in progress.
- stall_i  in  1  downstream hold; freezes all state.
- regwrite_o, memtoreg_o, memread_o, memwrite_o, alusrc_o, branch_o  out  1 each  registered control bundle.
- aluop_o  out  ALUOP_W  registered ALU op class.
- valid_o  out  1  bundle is a real instruction.
- mdu_start_o  out  1  one-cycle pulse; MDU latches its operands.
- mdu_op_o  out  3  funct3 of the M op. Valid with mdu_start_o and held through issue.
- mdu_kill_o  out  1  one-cycle pulse; MDU abandons the op in progress.
- busy_o  out  1  registered; front end must hold the PC and the IF/ID register.
- illegal_o  out  1  one-cycle pulse; undefined opcode decoded.

Behaviour:
- Reset (rst_i=0 at an edge): all outputs 0, aluop_o=00, FSM in IDLE, counter 0. Reset mid-MDU aborts silently; no kill pulse.
- Bubble: all bundle bits 0, aluop_o=00, valid_o=0.
- Per-edge priority: reset > flush > stall > noop > decode.
- Decode (IDLE, valid_i=1, no stall/flush/noop). Bundle reaches the outputs 1 cycle later:
  - 0110011 with funct7≠0000001: RW=1, ALUOp=R, ALUSrc=0.
  - 0010011: RW=1, ALUOp=I, ALUSrc=1.
  - 0000011: RW=1, MtoR=1, MemRd=1, ALUOp=I, ALUSrc=1.
  - 0100011: MemWr=1, ALUOp=S, ALUSrc=1, MtoR=0. No X is ever driven.
  - 1100011: Branch=1, ALUOp=SB, ALUSrc=0, MtoR=0.
  - Any other opcode: bubble, illegal_o pulse.
  - Every legal decode sets valid_o=1.
- valid_i=0 in IDLE: bubble.
- FSM states: IDLE, BUSY, ISSUE.
  - IDLE→BUSY on decode of 0110011 with funct7=0000001. Same edge: mdu_start_o=1 (1 cycle), mdu_op_o=funct3, busy_o=1, bundle = bubble, counter = LAT-1 (LAT = MUL_CYCLES or DIV_CYCLES).
  - BUSY, counter≠0: decrement counter; bundle stays bubble.
  - BUSY, counter=0 → ISSUE. At this edge: bundle = RW=1, ALUOp=R, ALUSrc=0, valid_o=1; busy_o=0.
  - ISSUE→IDLE next edge. ISSUE decodes inst_i normally, giving back-to-back issue.
  - busy_o is high for exactly LAT cycles. First M op result bundle appears LAT+1 cycles after acceptance.
- stall_i=1: every register and the counter hold, including busy_o. mdu_start_o, mdu_kill_o and illegal_o are forced 0 during stall (no repeated pulse).
- flush_i=1:
  - In BUSY: state→IDLE, bundle = bubble, busy_o=0, mdu_kill_o=1 for one cycle.
  - In IDLE/ISSUE: bundle = bubble, no kill.
- flush_i and stall_i together: flush wins.
- noop_i in BUSY is ignored; the sequencer owns the bundle.
- Counter is 8-bit and never wraps: loaded ≤254 and only decremented while ≠0.

Optional Feature:
- Macro CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_bubble_o[31:0] and perf_mdu_o[31:0].
  - perf_bubble_o counts edges that register a bubble while not in BUSY.
  - perf_mdu_o counts cycles with busy_o=1.
  - Both counters freeze on stall_i, clear on reset, and wrap modulo 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - FUNCT7_MULDIV;
  - ALUOp constants ALUOP_I/S/R/SB;
  - FSM state enum {IDLE, BUSY, ISSUE};
  - the control bundle struct.
- Sub-module ctrl_decode: purely combinational inst→bundle, is_mdu and illegal flags.
- The top module holds the FSM, counter, output registers and perf counters.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles, then issue addi 0x00500093 → one cycle later RW=1, ALUSrc=1, ALUOp=00, valid_o=1; all outputs 0 during reset.
- Sequence lw/sw/beq/add (0x0000A103, 0x0020A023, 0x00208463, 0x002081B3) → bundles per decode list at +1 cycle each; sw/beq show MtoR=0.
- mul 0x022081B3 with MUL_CYCLES=3 → mdu_start_o at +1, busy_o high for 3 cycles, R bundle valid at +4; div with DIV_CYCLES=32 → busy_o high for 32 cycles.
- div accepted, flush_i on the 5th busy cycle → mdu_kill_o pulse, busy_o=0 and bubble next cycle; following add issues normally.
- stall_i high for 4 cycles mid-mul → busy_o extends by exactly 4 cycles, no duplicate mdu_start_o; stall+flush in the same cycle → flush result.
- opcode 0x7F, noop_i=1 on a valid add, and with CTRL_PERF_EN: 10 bubbles → illegal_o one pulse, bubbles registered, perf_bubble_o=10.
